// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU operations, mux selects and
// the state encoding of the iterative multiply/divide unit.
package exe_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_SLLV  = 5'd11;
  localparam logic [4:0] ALU_SRLV  = 5'd12;
  localparam logic [4:0] ALU_SRAV  = 5'd13;
  localparam logic [4:0] ALU_LUI   = 5'd14;
  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MFHI  = 5'd20;
  localparam logic [4:0] ALU_MFLO  = 5'd21;
  localparam logic [4:0] ALU_MTHI  = 5'd22;
  localparam logic [4:0] ALU_MTLO  = 5'd23;

  localparam logic [1:0] SRC_RD2  = 2'b00;
  localparam logic [1:0] SRC_SIMM = 2'b01;
  localparam logic [1:0] SRC_ZIMM = 2'b10;

  localparam logic [1:0] FWD_RD  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] MDOP_MULT  = 2'd0;
  localparam logic [1:0] MDOP_MULTU = 2'd1;
  localparam logic [1:0] MDOP_DIV   = 2'd2;
  localparam logic [1:0] MDOP_DIVU  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;

  function automatic logic [1:0] md_sel(input logic [4:0] op);
    case (op)
      ALU_MULTU: md_sel = MDOP_MULTU;
      ALU_DIV:   md_sel = MDOP_DIV;
      ALU_DIVU:  md_sel = MDOP_DIVU;
      default:   md_sel = MDOP_MULT;
    endcase
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers; works on
// operand magnitudes and restores result signs on the final step.
module md_iter_unit
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, dvs, hi_r, lo_r;
  logic neg_lo, neg_hi;

  logic is_signed, a_neg, b_neg, last, div_ge;
  logic [WIDTH-1:0] mag_a, mag_b, acc_nx, mq_nx, rem_sub, fin_hi, fin_lo;
  logic [WIDTH:0] mul_sum, shifted;
  logic [2*WIDTH-1:0] prod_fix;

  // acc is the running high product / partial remainder, mq the multiplier /
  // dividend shifting out while product / quotient bits shift in.
  always_comb begin
    is_signed = (op == MDOP_MULT) || (op == MDOP_DIV);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;

    mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
    shifted = {acc, mq[WIDTH-1]};
    div_ge  = shifted >= {1'b0, dvs};
    rem_sub = shifted[WIDTH-1:0] - dvs;

    acc_nx = acc;
    mq_nx  = mq;
    if (state == S_MUL) begin
      acc_nx = mul_sum[WIDTH:1];
      mq_nx  = {mul_sum[0], mq[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      acc_nx = div_ge ? rem_sub : shifted[WIDTH-1:0];
      mq_nx  = {mq[WIDTH-2:0], div_ge};
    end

    prod_fix = neg_lo ? -{acc_nx, mq_nx} : {acc_nx, mq_nx};
    fin_lo   = neg_lo ? -mq_nx : mq_nx;
    fin_hi   = neg_hi ? -acc_nx : acc_nx;
    if (state == S_MUL) {fin_hi, fin_lo} = prod_fix;

    last     = (cnt == CW'(1));
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = op[1] ? S_DIV : S_MUL;
      default: if (last) state_nx = S_IDLE;
    endcase
  end

  // Divide by zero leaves the quotient unnegated so LO stays all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      dvs    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (start) begin
          cnt    <= CW'(WIDTH);
          acc    <= '0;
          mq     <= op[1] ? mag_a : mag_b;
          dvs    <= op[1] ? mag_b : mag_a;
          neg_lo <= (a_neg ^ b_neg) & (!op[1] || (b != '0));
          neg_hi <= a_neg & op[1];
        end else begin
          if (wr_hi) hi_r <= a;
          if (wr_lo) lo_r <= a;
        end
      end else begin
        cnt <= cnt - CW'(1);
        acc <= acc_nx;
        mq  <= mq_nx;
        if (last) begin
          hi_r <= fin_hi;
          lo_r <= fin_lo;
        end
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: rtl/execute_stage_md.sv
// MIPS execute stage: operand forwarding, srcB selection, ALU, iterative
// multiply/divide with HI/LO, stall request and the registered EX/MEM boundary.
module execute_stage_md
  import exe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidE,
  input  logic              RegDstE,
  input  logic [1:0]        ALUSrcE,
  input  logic [CTRL_W-1:0] ALUControlE,
  input  logic [4:0]        shamtE,
  input  logic [WIDTH-1:0]  Rd1E,
  input  logic [WIDTH-1:0]  Rd2E,
  input  logic [RA_W-1:0]   RsE,
  input  logic [RA_W-1:0]   RtE,
  input  logic [RA_W-1:0]   RdE,
  input  logic [15:0]       immE,
  input  logic [WIDTH-1:0]  signImmE,
  input  logic [WIDTH-1:0]  ALUOutMIn,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic [RA_W-1:0]   RsEtoHU,
  output logic [RA_W-1:0]   RtEtoHU,
  output logic              MdStallE,
  output logic              ValidM,
  output logic [WIDTH-1:0]  ALUOutM,
  output logic [WIDTH-1:0]  WriteDataM,
  output logic [RA_W-1:0]   WriteRegM,
  output logic              MdBusy
);

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res, hi, lo;
  logic md_group, md_arith, md_start, wr_hi, wr_lo;

  assign RsEtoHU = RsE;
  assign RtEtoHU = RtE;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUOutMIn;
      default: src_a = Rd1E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUOutMIn;
      default: fwd_b = Rd2E;
    endcase
    case (ALUSrcE)
      SRC_SIMM: src_b = signImmE;
      SRC_ZIMM: src_b = WIDTH'(immE);
      default:  src_b = fwd_b;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_b << shamtE;
      ALU_SRL:  alu_res = src_b >> shamtE;
      ALU_SRA:  alu_res = $signed(src_b) >>> shamtE;
      ALU_SLLV: alu_res = src_b << src_a[4:0];
      ALU_SRLV: alu_res = src_b >> src_a[4:0];
      ALU_SRAV: alu_res = $signed(src_b) >>> src_a[4:0];
      ALU_LUI:  alu_res = WIDTH'({immE, {WIDTH{1'b0}}} >> 16);
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  // Operands reach the unit only on the issue edge, so forwarding changes
  // during a stall are harmless.
  assign md_group = ALUControlE inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
                                        ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO};
  assign md_arith = ALUControlE inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  assign MdStallE = ValidE & MdBusy & md_group;
  assign md_start = ValidE & ~MdBusy & md_arith;
  assign wr_hi    = ValidE & ~MdStallE & (ALUControlE == ALU_MTHI);
  assign wr_lo    = ValidE & ~MdStallE & (ALUControlE == ALU_MTLO);

  md_iter_unit #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_sel(ALUControlE)),
    .a     (src_a),
    .b     (fwd_b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .busy  (MdBusy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidM     <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      ValidM     <= ValidE & ~MdStallE;
      ALUOutM    <= alu_res;
      WriteDataM <= fwd_b;
      WriteRegM  <= RegDstE ? RdE : RtE;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: directed corner cases plus random
// instructions compared against a cycle-level behavioural model.
module tb_execute_stage_md;
  import exe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ValidE, RegDstE;
  logic [1:0] ALUSrcE, ForwardAE, ForwardBE;
  logic [4:0] ALUControlE, shamtE, RsE, RtE, RdE;
  logic [31:0] Rd1E, Rd2E, signImmE, ALUOutMIn, ResultW;
  logic [15:0] immE;
  logic [4:0] RsEtoHU, RtEtoHU, WriteRegM;
  logic MdStallE, ValidM, MdBusy;
  logic [31:0] ALUOutM, WriteDataM;

  execute_stage_md #(.WIDTH(32), .RA_W(5), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .shamtE(shamtE), .Rd1E(Rd1E), .Rd2E(Rd2E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .immE(immE), .signImmE(signImmE),
    .ALUOutMIn(ALUOutMIn), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RsEtoHU(RsEtoHU), .RtEtoHU(RtEtoHU), .MdStallE(MdStallE), .ValidM(ValidM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .MdBusy(MdBusy)
  );

  // 16-bit instance for the narrow-datapath multiply
  logic s_valid;
  logic [4:0] s_op, s_rsHU, s_rtHU, s_wreg;
  logic [15:0] s_rd1, s_rd2, s_aluout, s_wdata;
  logic s_stall, s_validm, s_busy;

  execute_stage_md #(.WIDTH(16), .RA_W(5), .CTRL_W(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .ValidE(s_valid), .RegDstE(1'b0), .ALUSrcE(2'b00),
    .ALUControlE(s_op), .shamtE(5'd0), .Rd1E(s_rd1), .Rd2E(s_rd2),
    .RsE(5'd0), .RtE(5'd0), .RdE(5'd0), .immE(16'h0), .signImmE(16'h0),
    .ALUOutMIn(16'h0), .ResultW(16'h0), .ForwardAE(2'b00), .ForwardBE(2'b00),
    .RsEtoHU(s_rsHU), .RtEtoHU(s_rtHU), .MdStallE(s_stall), .ValidM(s_validm),
    .ALUOutM(s_aluout), .WriteDataM(s_wdata), .WriteRegM(s_wreg), .MdBusy(s_busy)
  );

  int checkCount = 0;
  int passCount  = 0;
  int stallSeen  = 0;
  logic lastStall;

  // Model state: architectural HI/LO, cycles left on the unit, pending result
  logic [31:0] mHi, mLo, pHi, pLo;
  int mCnt;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] fwdSel(input logic [1:0] sel, input logic [31:0] rd,
                                         input logic [31:0] resW, input logic [31:0] aluM);
    if (sel == 2'b01) return resW;
    if (sel == 2'b10) return aluM;
    return rd;
  endfunction

  function automatic logic isMd(input logic [4:0] op);
    return (op >= ALU_MULT) && (op <= ALU_MTLO);
  endfunction

  function automatic logic isMdArith(input logic [4:0] op);
    return (op >= ALU_MULT) && (op <= ALU_DIVU);
  endfunction

  function automatic logic [31:0] refAlu(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh,
                                         input logic [15:0] imm);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return $signed(b) >>> sh;
      ALU_SLLV: return b << a[4:0];
      ALU_SRLV: return b >> a[4:0];
      ALU_SRAV: return $signed(b) >>> a[4:0];
      ALU_LUI:  return {imm, 16'h0000};
      ALU_MFHI: return mHi;
      ALU_MFLO: return mLo;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic mdRef(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {hi, lo} = sp;
      end
      ALU_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        {hi, lo} = up;
      end
      ALU_DIV: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = a; hi = 32'h0; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // One instruction slot: drive, check combinational outputs, clock, advance
  // the model, then check the EX/MEM register and busy flag.
  task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [1:0] src, input logic [15:0] imm, input logic [4:0] sh,
                               input logic [31:0] aluM, input logic [31:0] resW);
    logic [31:0] a, bf, b, expRes;
    logic [4:0] rs, rt, rd;
    logic rdst, expStall;
    rs = 5'($urandom);
    rt = 5'($urandom);
    rd = 5'($urandom);
    rdst = 1'($urandom);
    ValidE = v; ALUControlE = op; Rd1E = rd1; Rd2E = rd2; ForwardAE = fa; ForwardBE = fb;
    ALUSrcE = src; immE = imm; signImmE = {{16{imm[15]}}, imm}; shamtE = sh;
    ALUOutMIn = aluM; ResultW = resW; RsE = rs; RtE = rt; RdE = rd; RegDstE = rdst;
    a  = fwdSel(fa, rd1, resW, aluM);
    bf = fwdSel(fb, rd2, resW, aluM);
    b  = (src == 2'b01) ? {{16{imm[15]}}, imm} : (src == 2'b10) ? {16'h0, imm} : bf;
    expStall = v && (mCnt > 0) && isMd(op);
    expRes = refAlu(op, a, b, sh, imm);
    #1;
    checkOutput("MdStallE", 64'(MdStallE), 64'(expStall));
    checkOutput("RsEtoHU", 64'(RsEtoHU), 64'(rs));
    checkOutput("RtEtoHU", 64'(RtEtoHU), 64'(rt));
    if (MdStallE) stallSeen++;
    lastStall = expStall;
    @(posedge clk);
    if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) begin mHi = pHi; mLo = pLo; end
    end else if (v && isMdArith(op)) begin
      mdRef(op, a, bf, pHi, pLo);
      mCnt = 32;
    end else if (v && op == ALU_MTHI) mHi = a;
    else if (v && op == ALU_MTLO) mLo = a;
    #1;
    checkOutput("ValidM", 64'(ValidM), 64'(v && !expStall));
    checkOutput("WriteDataM", 64'(WriteDataM), 64'(bf));
    checkOutput("WriteRegM", 64'(WriteRegM), 64'(rdst ? rd : rt));
    checkOutput("MdBusy", 64'(MdBusy), 64'(mCnt > 0));
    if (!(isMdArith(op) || op == ALU_MTHI || op == ALU_MTLO))
      checkOutput("ALUOutM", 64'(ALUOutM), 64'(expRes));
  endtask

  // Re-present the same instruction while it is held by a stall.
  task automatic holdIssue(input logic [4:0] op, input logic [31:0] rd1, input logic [31:0] rd2);
    applyStimulus(1'b1, op, rd1, rd2, 2'b00, 2'b00, 2'b00, 16'h0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 80 && lastStall; i++)
      applyStimulus(1'b1, op, rd1, rd2, 2'b00, 2'b00, 2'b00, 16'h0, 5'd0, 32'h0, 32'h0);
    if (lastStall) checkOutput("holdTimeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    logic [4:0] op;
    rst_n = 1'b0;
    ValidE = 0; RegDstE = 0; ALUSrcE = 0; ALUControlE = 0; shamtE = 0; Rd1E = 0; Rd2E = 0;
    RsE = 0; RtE = 0; RdE = 0; immE = 0; signImmE = 0; ALUOutMIn = 0; ResultW = 0;
    ForwardAE = 0; ForwardBE = 0;
    s_valid = 0; s_op = ALU_ADD; s_rd1 = 0; s_rd2 = 0;
    mHi = 0; mLo = 0; pHi = 0; pLo = 0; mCnt = 0; lastStall = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValidM", 64'(ValidM), 64'd0);
    checkOutput("rstALUOutM", 64'(ALUOutM), 64'd0);
    checkOutput("rstWriteDataM", 64'(WriteDataM), 64'd0);
    checkOutput("rstWriteRegM", 64'(WriteRegM), 64'd0);
    checkOutput("rstMdBusy", 64'(MdBusy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] forwarding and immediate select");
    applyStimulus(1'b1, ALU_ADD, 32'h11, 32'd3, 2'b10, 2'b00, 2'b00, 16'h1234, 5'd0, 32'd5, 32'h77);
    checkOutput("fwdAdd", 64'(ALUOutM), 64'd8);
    applyStimulus(1'b1, ALU_OR, 32'h0, 32'h55, 2'b00, 2'b00, 2'b10, 16'hFFFF, 5'd0, 32'h9, 32'h9);
    checkOutput("zimmOr", 64'(ALUOutM), 64'h0000FFFF);

    $display("[TB] signed multiply");
    holdIssue(ALU_MULT, 32'hFFFFFFFD, 32'd7);
    stallSeen = 0;
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("mulStalls", 64'(stallSeen), 64'd32);
    checkOutput("multLo", 64'(ALUOutM), 64'hFFFFFFEB);
    holdIssue(ALU_MFHI, 32'h0, 32'h0);
    checkOutput("multHi", 64'(ALUOutM), 64'hFFFFFFFF);

    $display("[TB] divide corner cases");
    holdIssue(ALU_DIV, 32'hFFFFFFF9, 32'd2);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("divLo", 64'(ALUOutM), 64'hFFFFFFFD);
    holdIssue(ALU_MFHI, 32'h0, 32'h0);
    checkOutput("divHi", 64'(ALUOutM), 64'hFFFFFFFF);
    holdIssue(ALU_DIVU, 32'd9, 32'd0);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("div0Lo", 64'(ALUOutM), 64'hFFFFFFFF);
    holdIssue(ALU_MFHI, 32'h0, 32'h0);
    checkOutput("div0Hi", 64'(ALUOutM), 64'd9);
    holdIssue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("minDivLo", 64'(ALUOutM), 64'h80000000);
    holdIssue(ALU_MFHI, 32'h0, 32'h0);
    checkOutput("minDivHi", 64'(ALUOutM), 64'h0);

    $display("[TB] overlap with independent instructions");
    holdIssue(ALU_DIVU, $urandom, $urandom | 32'h1);
    stallSeen = 0;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, ALU_ADD, $urandom, $urandom, 2'b00, 2'b00, 2'b00, 16'h0, 5'd0,
                    $urandom, $urandom);
    checkOutput("overlapNoStall", 64'(stallSeen), 64'd0);
    holdIssue(ALU_MULT, $urandom, $urandom);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);

    $display("[TB] reset during multiply");
    holdIssue(ALU_MULT, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) applyStimulus(1'b1, ALU_ADD, $urandom, $urandom, 2'b00, 2'b00, 2'b00, 16'h0,
                             5'd0, 32'h0, 32'h0);
    ValidE = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abortMdBusy", 64'(MdBusy), 64'd0);
    checkOutput("abortValidM", 64'(ValidM), 64'd0);
    checkOutput("abortALUOutM", 64'(ALUOutM), 64'd0);
    mHi = 0; mLo = 0; mCnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    holdIssue(ALU_MFHI, 32'h0, 32'h0);
    checkOutput("abortHi", 64'(ALUOutM), 64'd0);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("abortLo", 64'(ALUOutM), 64'd0);
    holdIssue(ALU_MULT, 32'd6, 32'd7);
    holdIssue(ALU_MFLO, 32'h0, 32'h0);
    checkOutput("postRstMult", 64'(ALUOutM), 64'd42);

    $display("[TB] random instruction stream");
    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(3, 0) == 0) ? 5'(ALU_MULT + 5'($urandom_range(7, 0)))
                                       : 5'($urandom_range(14, 0));
      applyStimulus(($urandom_range(7, 0) != 0), op, $urandom, $urandom, 2'($urandom),
                    2'($urandom), 2'($urandom), 16'($urandom), 5'($urandom), $urandom, $urandom);
      for (int k = 0; k < 80 && lastStall; k++)
        applyStimulus(1'b1, op, Rd1E, Rd2E, ForwardAE, ForwardBE, ALUSrcE, immE, shamtE,
                      ALUOutMIn, ResultW);
      if (lastStall) checkOutput("randTimeout", 64'd1, 64'd0);
    end

    $display("[TB] 16-bit datapath multiply");
    s_valid = 1'b1; s_op = ALU_MULTU; s_rd1 = 16'hFFFF; s_rd2 = 16'hFFFF;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    n = 0;
    while (s_busy && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("w16Busy", 64'(n), 64'd16);
    s_valid = 1'b1; s_op = ALU_MFHI;
    @(posedge clk);
    #1;
    checkOutput("w16Hi", 64'(s_aluout), 64'hFFFE);
    s_op = ALU_MFLO;
    @(posedge clk);
    #1;
    checkOutput("w16Lo", 64'(s_aluout), 64'h0001);
    checkOutput("w16ValidM", 64'(s_validm), 64'd1);
    s_valid = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
